// File: rtl/arb_pkg.sv
// Shared constants, state encoding and one-hot helper for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Pointer starts at the last requester so that requester 0 wins the first search.
  localparam logic [IDX_W-1:0] PTR_RST = 3'd7;

  function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: rotate req so ptr+1 lands at bit 0, take the
// lowest set bit, then rotate the chosen index back to requester numbering.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_pick,
  output logic [IDX_W-1:0] o_pick_idx,
  output logic             o_pick_valid
);
  logic [IDX_W-1:0] w_shift;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_sel;
  logic             w_any;
  logic [IDX_W-1:0] w_k;

  assign w_shift = i_ptr + 3'd1;

  always_comb begin
    w_rot = '0;
    w_k   = '0;
    for (int i = 0; i < N; i++) begin
      w_k      = w_shift + IDX_W'(i);
      w_rot[i] = i_req[w_k];
    end
  end

  // Descending scan so the lowest rotated position is written last and wins.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_sel = IDX_W'(i);
        w_any = 1'b1;
      end
    end
  end

  assign o_pick_valid = w_any;
  assign o_pick_idx   = w_any ? (w_sel + w_shift) : '0;
  assign o_pick       = w_any ? idx_to_onehot(o_pick_idx) : '0;
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant and index.
// Optional forced revoke after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [N-1:0]     i_req,
  input  logic             i_release,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_valid,
  output logic             o_timeout
);
`ifdef ARB_TIMEOUT_EN
  localparam logic TIMEOUT_ON = 1'b1;
`else
  localparam logic TIMEOUT_ON = 1'b0;
`endif
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [7:0]       r_hold_cnt;
  logic [N-1:0]     r_grant;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_grant_valid;
  logic             r_timeout;

  logic [N-1:0]     w_pick;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_valid;
  logic             w_owner_req;
  logic             w_timeout_hit;
  logic             w_release;

  rr_pick8 u_pick (
    .i_req        (i_req),
    .i_ptr        (r_ptr),
    .o_pick       (w_pick),
    .o_pick_idx   (w_pick_idx),
    .o_pick_valid (w_pick_valid)
  );

  // While granted, ptr equals the owner, so the owner is searched last.
  assign w_owner_req   = |(i_req & r_grant);
  assign w_timeout_hit = TIMEOUT_ON & (r_hold_cnt == HOLD_LAST);
  assign w_release     = i_release | ~w_owner_req | w_timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= PTR_RST;
      r_hold_cnt    <= '0;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else if (!i_en) begin
      r_state       <= IDLE;
      r_hold_cnt    <= '0;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          if (w_pick_valid) begin
            r_state       <= GRANT;
            r_ptr         <= w_pick_idx;
            r_hold_cnt    <= '0;
            r_grant       <= w_pick;
            r_grant_idx   <= w_pick_idx;
            r_grant_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_timeout  <= w_timeout_hit;
            r_hold_cnt <= '0;
            if (w_pick_valid) begin
              r_ptr         <= w_pick_idx;
              r_grant       <= w_pick;
              r_grant_idx   <= w_pick_idx;
              r_grant_valid <= 1'b1;
            end else begin
              r_state       <= IDLE;
              r_grant       <= '0;
              r_grant_idx   <= '0;
              r_grant_valid <= 1'b0;
            end
          end else begin
            r_timeout <= 1'b0;
            if (r_hold_cnt != 8'hFF) r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_idx   = r_grant_idx;
  assign o_grant_valid = r_grant_valid;
  assign o_timeout     = r_timeout;
endmodule
